// File: rtl/mem_io_pkg.sv
// Shared types and constants for the CPU-side memory/IO bridge.
package mem_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    WH,
    DONE
  } state_t;

  localparam logic [19:0] DEF_IO_ADDR = 20'hFFFFF;
  localparam int unsigned WAIT_W      = 4;

endpackage

// File: rtl/mem_io_ctrl_sync2.sv
// Parametrised-width two-flop synchroniser for asynchronous board inputs.
module sync2 #(
  parameter int unsigned W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First flop may go metastable; second flop presents a settled value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_io_ctrl.sv
// CPU request bridge: routes single-word accesses to async SRAM or the IO word.
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 20,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       NUM_HEX     = 4,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR     = DEF_IO_ADDR
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  ready,
  output logic [DATA_W-1:0]     rdata,
  input  logic [DATA_W-1:0]     switches,
  output logic [NUM_HEX*4-1:0]  hex_digits,
  output logic                  CE_N,
  output logic                  OE_N,
  output logic                  WE_N,
  output logic                  UB_N,
  output logic                  LB_N,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_dout,
  output logic                  sram_drive,
  input  logic [DATA_W-1:0]     sram_din
);

  localparam int unsigned        HEX_W     = NUM_HEX * 4;
  localparam int unsigned        HALF_W    = DATA_W / 2;
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(WAIT_CYCLES);

  state_t              state;
  logic [WAIT_W-1:0]   cnt;
  logic [1:0]          be_q;
  logic [DATA_W-1:0]   sw_sync;
  logic [HEX_W-1:0]    hex_wr;
  logic [DATA_W-1:0]   rd_mask;
  logic                is_io;

  sync2 #(.W(DATA_W)) u_sw_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (switches),
    .q     (sw_sync)
  );

  // Display register is loaded from the low data bits, zero-extended if wider.
  if (HEX_W > DATA_W) begin : g_hex_ext
    assign hex_wr = {{(HEX_W - DATA_W){1'b0}}, wdata};
  end else begin : g_hex_trunc
    assign hex_wr = wdata[HEX_W-1:0];
  end

  assign is_io   = (addr == IO_ADDR);
  assign rd_mask = {{HALF_W{be_q[1]}}, {HALF_W{be_q[0]}}};

  // Access sequencer; strobes and ready are registered so outputs are glitch-free.
  // ready is raised on the edge leaving DONE, so the CPU sees it in the IDLE cycle
  // that follows, and a held req is then taken on the edge ending that cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      be_q       <= '0;
      ready      <= 1'b0;
      rdata      <= '0;
      hex_digits <= '0;
      CE_N       <= 1'b1;
      OE_N       <= 1'b1;
      WE_N       <= 1'b1;
      UB_N       <= 1'b1;
      LB_N       <= 1'b1;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_drive <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            cnt <= '0;
            if (is_io) begin
              if (we) hex_digits <= hex_wr;
              else    rdata      <= sw_sync;
              state <= DONE;
            end else begin
              sram_addr <= addr;
              be_q      <= be;
              CE_N      <= 1'b0;
              UB_N      <= ~be[1];
              LB_N      <= ~be[0];
              if (we) begin
                sram_dout  <= wdata;
                sram_drive <= 1'b1;
                WE_N       <= 1'b0;
                state      <= WR;
              end else begin
                OE_N  <= 1'b0;
                state <= RD;
              end
            end
          end
        end
        RD: begin
          if (cnt == WAIT_LAST) begin
            rdata <= sram_din & rd_mask;
            CE_N  <= 1'b1;
            OE_N  <= 1'b1;
            UB_N  <= 1'b1;
            LB_N  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR: begin
          if (cnt == WAIT_LAST) begin
            WE_N  <= 1'b1;
            state <= WH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WH: begin
          CE_N       <= 1'b1;
          UB_N       <= 1'b1;
          LB_N       <= 1'b1;
          sram_drive <= 1'b0;
          state      <= DONE;
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Self-checking bench for mem_io_ctrl: vector table with scoreboard plus corner sequences.
module tb_mem_io_ctrl;

  localparam int unsigned W2 = 2;

  logic        Clk, Reset, req, req0, we;
  logic [1:0]  be;
  logic [19:0] addr;
  logic [15:0] wdata, switches, sram_din;

  logic        ready, CE_N, OE_N, WE_N, UB_N, LB_N, sram_drive;
  logic [15:0] rdata, hex_digits, sram_dout;
  logic [19:0] sram_addr;

  logic        ready_0, CE_N_0, OE_N_0, WE_N_0, UB_N_0, LB_N_0, sram_drive_0;
  logic [15:0] rdata_0, hex_digits_0, sram_dout_0;
  logic [19:0] sram_addr_0;

  mem_io_ctrl #(.WAIT_CYCLES(W2)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .ready(ready), .rdata(rdata), .switches(switches),
    .hex_digits(hex_digits), .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N),
    .UB_N(UB_N), .LB_N(LB_N), .sram_addr(sram_addr), .sram_dout(sram_dout),
    .sram_drive(sram_drive), .sram_din(sram_din)
  );

  mem_io_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .req(req0), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .ready(ready_0), .rdata(rdata_0), .switches(switches),
    .hex_digits(hex_digits_0), .CE_N(CE_N_0), .OE_N(OE_N_0), .WE_N(WE_N_0),
    .UB_N(UB_N_0), .LB_N(LB_N_0), .sram_addr(sram_addr_0), .sram_dout(sram_dout_0),
    .sram_drive(sram_drive_0), .sram_din(sram_din)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    logic [15:0] sw;
    logic [15:0] exp_rdata;
    logic [15:0] exp_hex;
    int unsigned exp_lat;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic [15:0] hex;
    logic [19:0] saddr;
    int unsigned lat;
    int unsigned oe_cyc;
    int unsigned we_cyc;
    int unsigned ce_cyc;
    logic        ub;
    logic        lb;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [19:0] model_saddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] b, input logic [19:0] a,
                              input logic [15:0] wd, input logic [15:0] di, input logic [15:0] s,
                              input logic [15:0] er, input logic [15:0] eh, input int unsigned el);
    vec_t v;
    v.we = w; v.be = b; v.addr = a; v.wdata = wd; v.din = di; v.sw = s;
    v.exp_rdata = er; v.exp_hex = eh; v.exp_lat = el;
    return v;
  endfunction

  // Drive one request on the WAIT_CYCLES=2 instance, push expectations, compare on ready.
  task automatic run_vec(input vec_t v);
    exp_t        e, g;
    logic        io, got;
    int unsigned k;
    io = (v.addr == 20'hFFFFF);
    @(negedge Clk);
    req = 1'b1; we = v.we; be = v.be; addr = v.addr;
    wdata = v.wdata; sram_din = v.din; switches = v.sw;
    if (!io) model_saddr = v.addr;
    e.rdata  = v.exp_rdata;
    e.hex    = v.exp_hex;
    e.saddr  = model_saddr;
    e.lat    = v.exp_lat;
    e.oe_cyc = (!io && !v.we) ? W2 + 1 : 0;
    e.we_cyc = (!io &&  v.we) ? W2 + 1 : 0;
    e.ce_cyc = io ? 0 : (v.we ? W2 + 2 : W2 + 1);
    e.ub     = !io && v.be[1];
    e.lb     = !io && v.be[0];
    sb.push_back(e);
    g.oe_cyc = 0; g.we_cyc = 0; g.ce_cyc = 0; g.ub = 1'b0; g.lb = 1'b0;
    got = 1'b0; k = 0;
    @(posedge Clk);
    while (!got && k <= 20) begin
      @(negedge Clk);
      if (ready) got = 1'b1;
      else begin
        if (!OE_N) g.oe_cyc++;
        if (!WE_N) g.we_cyc++;
        if (!CE_N) g.ce_cyc++;
        if (!UB_N) g.ub = 1'b1;
        if (!LB_N) g.lb = 1'b1;
        @(posedge Clk);
        k++;
      end
    end
    req = 1'b0;
    e = sb.pop_front();
    check("ready_seen", {31'd0, got}, 32'd1);
    check("latency", k, e.lat);
    check("rdata", rdata, e.rdata);
    check("hex_digits", hex_digits, e.hex);
    check("sram_addr", sram_addr, e.saddr);
    check("oe_cycles", e.oe_cyc == g.oe_cyc ? 32'd1 : 32'd0, 32'd1);
    check("we_cycles", g.we_cyc, e.we_cyc);
    check("ce_cycles", g.ce_cyc, e.ce_cyc);
    check("ub_active", {31'd0, g.ub}, {31'd0, e.ub});
    check("lb_active", {31'd0, g.lb}, {31'd0, e.lb});
  endtask

  vec_t vecs[11];
  vec_t vr;
  logic seen;
  int unsigned hits, first_k, second_k;
  logic oe5, oe10;

  initial begin
    Reset = 1'b1; req = 1'b0; req0 = 1'b0; we = 1'b0; be = 2'b00; addr = '0;
    wdata = '0; switches = 16'h1234; sram_din = '0; model_saddr = '0;

    //            we    be     addr       wdata     din       sw        rdata     hex       lat
    vecs[0]  = mk(1'b1, 2'b11, 20'hFFFFF, 16'hBEEF, 16'h0000, 16'h1234, 16'h0000, 16'hBEEF, 1);
    vecs[1]  = mk(1'b0, 2'b11, 20'h00010, 16'h0000, 16'hA55A, 16'h1234, 16'hA55A, 16'hBEEF, 4);
    vecs[2]  = mk(1'b0, 2'b01, 20'h00010, 16'h0000, 16'hA55A, 16'h1234, 16'h005A, 16'hBEEF, 4);
    vecs[3]  = mk(1'b0, 2'b10, 20'h00011, 16'h0000, 16'hA55A, 16'h1234, 16'hA500, 16'hBEEF, 4);
    vecs[4]  = mk(1'b0, 2'b00, 20'h00012, 16'h0000, 16'hA55A, 16'h1234, 16'h0000, 16'hBEEF, 4);
    vecs[5]  = mk(1'b1, 2'b11, 20'h00020, 16'hC0DE, 16'hFFFF, 16'h1234, 16'h0000, 16'hBEEF, 5);
    vecs[6]  = mk(1'b0, 2'b11, 20'hFFFFF, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 16'hBEEF, 1);
    vecs[7]  = mk(1'b1, 2'b00, 20'hFFFFF, 16'h0F0F, 16'h0000, 16'h1234, 16'h1234, 16'h0F0F, 1);
    vecs[8]  = mk(1'b0, 2'b11, 20'hFFFFE, 16'h0000, 16'h1357, 16'h1234, 16'h1357, 16'h0F0F, 4);
    vecs[9]  = mk(1'b0, 2'b11, 20'hFFFFF, 16'h0000, 16'h0000, 16'h5678, 16'h1234, 16'h0F0F, 1);
    vecs[10] = mk(1'b0, 2'b11, 20'hFFFFF, 16'h0000, 16'h0000, 16'h5678, 16'h5678, 16'h0F0F, 1);

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_strobes", {27'd0, CE_N, OE_N, WE_N, UB_N, LB_N}, 32'h1F);
    check("rst_drive", {31'd0, sram_drive}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_hex", hex_digits, 32'd0);
    check("rst_saddr", sram_addr, 32'd0);

    for (int unsigned i = 0; i < 11; i++) run_vec(vecs[i]);

    // Reset mid-read aborts the access without a ready pulse.
    @(negedge Clk);
    req = 1'b1; we = 1'b0; be = 2'b11; addr = 20'h00030; sram_din = 16'hFFFF;
    @(posedge Clk);
    @(negedge Clk);
    check("abort_in_rd", {31'd0, OE_N}, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1; req = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("abort_strobes", {27'd0, CE_N, OE_N, WE_N, UB_N, LB_N}, 32'h1F);
    check("abort_drive", {31'd0, sram_drive}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_saddr", sram_addr, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    Reset = 1'b0;
    model_saddr = '0;
    seen = 1'b0;
    for (int unsigned c = 0; c < 6; c++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (ready) seen = 1'b1;
    end
    check("abort_no_ready", {31'd0, seen}, 32'd0);
    vr = mk(1'b0, 2'b11, 20'hFFFFF, 16'h0000, 16'h0000, 16'h5678, 16'h5678, 16'h0000, 1);
    run_vec(vr);

    // Zero-wait write on the second instance: WR, WH hold cycle, DONE, ready.
    @(negedge Clk);
    req0 = 1'b1; we = 1'b1; be = 2'b11; addr = 20'h00040; wdata = 16'hC0DE;
    @(posedge Clk);
    @(negedge Clk);
    check("w0_wr_strobes", {29'd0, CE_N_0, WE_N_0, OE_N_0}, 32'h1);
    check("w0_wr_drive", {31'd0, sram_drive_0}, 32'd1);
    check("w0_wr_dout", sram_dout_0, 32'hC0DE);
    check("w0_wr_addr", sram_addr_0, 32'h00040);
    @(posedge Clk);
    @(negedge Clk);
    check("w0_wh_strobes", {29'd0, CE_N_0, WE_N_0, OE_N_0}, 32'h3);
    check("w0_wh_drive", {31'd0, sram_drive_0}, 32'd1);
    check("w0_wh_dout", sram_dout_0, 32'hC0DE);
    check("w0_wh_ready", {31'd0, ready_0}, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    check("w0_done_drive", {31'd0, sram_drive_0}, 32'd0);
    check("w0_done_ce", {31'd0, CE_N_0}, 32'd1);
    check("w0_done_ready", {31'd0, ready_0}, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    check("w0_ready", {31'd0, ready_0}, 32'd1);
    req0 = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("w0_ready_pulse", {31'd0, ready_0}, 32'd0);

    // req held high: second accept lands on the edge that ends the ready cycle.
    @(negedge Clk);
    req = 1'b1; we = 1'b0; be = 2'b11; addr = 20'h00010; sram_din = 16'hA55A;
    hits = 0; first_k = 99; second_k = 99; oe5 = 1'bx; oe10 = 1'bx;
    @(posedge Clk);
    for (int unsigned k = 0; k < 12; k++) begin
      @(negedge Clk);
      if (k == 5)  oe5  = OE_N;
      if (k == 10) oe10 = OE_N;
      if (ready) begin
        hits++;
        if (hits == 1) first_k = k;
        else if (hits == 2) begin
          second_k = k;
          req = 1'b0;
        end
      end
      @(posedge Clk);
    end
    req = 1'b0;
    check("b2b_first_ready", first_k, 32'd4);
    check("b2b_second_ready", second_k, 32'd9);
    check("b2b_ready_count", hits, 32'd2);
    check("b2b_reaccept", {31'd0, oe5}, 32'd0);
    check("b2b_no_third", {31'd0, oe10}, 32'd1);
    check("b2b_rdata", rdata, 32'hA55A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
